// File: rtl/lc3b_mem_stage.sv
// lc3b MEM stage: decodes memory opcodes, sequences one or two data-memory accesses (LDI/STI), stalls upstream.
// Optional perf counters enabled by defining LC3B_MEM_STAGE_PERF_EN.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_four;
  typedef logic [2:0]  lc3b_nzp;

  localparam lc3b_four OP_LDB = 4'b0010;
  localparam lc3b_four OP_LDW = 4'b0110;
  localparam lc3b_four OP_LDI = 4'b1010;
  localparam lc3b_four OP_STB = 4'b0011;
  localparam lc3b_four OP_STW = 4'b0111;
  localparam lc3b_four OP_STI = 4'b1011;
endpackage

module lc3b_mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  lc3b_word    ex_address,
  input  lc3b_word    ex_data,
  input  lc3b_word    ex_npc,
  input  lc3b_word    ex_aluresult,
  input  lc3b_word    ex_ir,
  input  lc3b_four    ex_cs,
  input  lc3b_nzp     ex_drid,
  output lc3b_word    dmem_address,
  output lc3b_word    dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        dmem_read,
  output logic        dmem_write,
  input  lc3b_word    dmem_rdata,
  input  logic        dmem_resp,
  output logic        wb_load,
  output lc3b_word    wb_address,
  output lc3b_word    wb_data,
  output lc3b_word    wb_npc,
  output lc3b_word    wb_aluresult,
  output lc3b_word    wb_ir,
  output lc3b_four    wb_cs,
  output lc3b_nzp     wb_drid,
  output logic        mem_stall,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_mem_ops
);
  typedef enum logic {IDLE, IND} state_t;

  state_t   state, state_nxt;
  lc3b_word ind_addr;
  lc3b_four opcode;
  logic     is_rd, is_wr, is_ind, is_byte, is_mem;
  logic     rd, wr, word, complete, latch_ptr;
  lc3b_word acc_addr;
  logic [7:0] ld_byte;

  assign opcode  = ex_ir[15:12];
  assign is_rd   = (opcode == OP_LDB) || (opcode == OP_LDW) || (opcode == OP_LDI);
  assign is_wr   = (opcode == OP_STB) || (opcode == OP_STW) || (opcode == OP_STI);
  assign is_ind  = (opcode == OP_LDI) || (opcode == OP_STI);
  assign is_byte = (opcode == OP_LDB) || (opcode == OP_STB);
  assign is_mem  = is_rd | is_wr;

  always_comb begin
    state_nxt        = state;
    rd               = 1'b0;
    wr               = 1'b0;
    word             = 1'b1;
    complete         = 1'b0;
    latch_ptr        = 1'b0;
    acc_addr         = ex_address;
    dmem_byte_enable = 2'b11;
    dmem_wdata       = ex_data;
    unique case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            complete = 1'b1;
          end else begin
            // indirect ops always fetch the pointer with a word read first
            rd   = is_rd | is_ind;
            wr   = is_wr & ~is_ind;
            word = is_ind | ~is_byte;
            if (!word) begin
              dmem_byte_enable = ex_address[0] ? 2'b10 : 2'b01;
              dmem_wdata       = {ex_data[7:0], ex_data[7:0]};
            end
            if (dmem_resp) begin
              if (is_ind) begin
                latch_ptr = 1'b1;
                state_nxt = IND;
              end else begin
                complete = 1'b1;
              end
            end
          end
        end
      end
      IND: begin
        acc_addr = ind_addr;
        if (ex_valid) begin
          rd = is_rd;
          wr = is_wr;
          if (dmem_resp) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ind_addr <= '0;
    end else begin
      state <= state_nxt;
      if (latch_ptr) ind_addr <= dmem_rdata;
    end
  end

  // strobes and handshake outputs are gated so reset silences them immediately
  assign dmem_address = word ? {acc_addr[15:1], 1'b0} : acc_addr;
  assign dmem_read    = rd & rst_n;
  assign dmem_write   = wr & rst_n;
  assign wb_load      = complete & rst_n;
  assign mem_stall    = ex_valid & rst_n & ~complete;

  assign ld_byte = ex_address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

  always_comb begin
    wb_data = ex_data;
    if (is_rd) wb_data = is_byte ? {{8{ld_byte[7]}}, ld_byte} : dmem_rdata;
  end

  assign wb_address   = is_ind ? ind_addr : ex_address;
  assign wb_npc       = ex_npc;
  assign wb_aluresult = ex_aluresult;
  assign wb_ir        = ex_ir;
  assign wb_cs        = ex_cs;
  assign wb_drid      = ex_drid;

`ifdef LC3B_MEM_STAGE_PERF_EN
  logic [31:0] stall_cnt, ops_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      ops_cnt   <= '0;
    end else begin
      if (mem_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (wb_load && is_mem && ops_cnt != '1) ops_cnt <= ops_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_mem_ops      = ops_cnt;
`else
  assign perf_stall_cycles = '0;
  assign perf_mem_ops      = '0;
`endif

endmodule

// File: tb/tb_lc3b_mem_stage.sv
// Randomized bench for lc3b_mem_stage: per-instruction access-list model, a memory responder and a per-cycle compare.
`timescale 1ns/1ps
module tb_lc3b_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_address = '0, ex_data = '0, ex_npc = '0, ex_aluresult = '0, ex_ir = '0;
  logic [3:0]  ex_cs = '0;
  logic [2:0]  ex_drid = '0;
  logic [15:0] dmem_address, dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic        wb_load, mem_stall;
  logic [15:0] wb_address, wb_data, wb_npc, wb_aluresult, wb_ir;
  logic [3:0]  wb_cs;
  logic [2:0]  wb_drid;
  logic [31:0] perf_stall_cycles, perf_mem_ops;

  always #5 clk = ~clk;

  lc3b_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .ex_address(ex_address), .ex_data(ex_data), .ex_npc(ex_npc),
    .ex_aluresult(ex_aluresult), .ex_ir(ex_ir), .ex_cs(ex_cs), .ex_drid(ex_drid),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .wb_load(wb_load), .wb_address(wb_address), .wb_data(wb_data), .wb_npc(wb_npc),
    .wb_aluresult(wb_aluresult), .wb_ir(wb_ir), .wb_cs(wb_cs), .wb_drid(wb_drid),
    .mem_stall(mem_stall), .perf_stall_cycles(perf_stall_cycles), .perf_mem_ops(perf_mem_ops)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] mem [0:32767];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } acc_t;

  // model of the instruction currently held in EX/MEM
  acc_t        acc [2];
  int          n_acc, acc_idx;
  bit          active = 0, done = 0, exp_memop;
  logic [15:0] exp_data, exp_addr, cur_npc, cur_alu, cur_ir;
  logic [3:0]  cur_cs;
  logic [2:0]  cur_drid;
  int unsigned exp_stall = 0, exp_ops = 0;
  int          wait_cnt = 0;

  // observations of the last instruction, for hand-computed checks
  int          obs_stall;
  logic [15:0] obs_data, obs_addr, obs_a0, obs_wd0;
  logic [1:0]  obs_be0;
  logic        obs_wr0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic acc_t mk(input logic r, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input logic [1:0] be);
    acc_t t;
    t.rd = r; t.wr = w; t.addr = a; t.wdata = d; t.be = be;
    return t;
  endfunction

  task automatic issue(input logic [15:0] ir, input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] w, ptr, aw, pw;
    logic [7:0]  b;
    ex_valid = 1'b1; ex_ir = ir; ex_address = addr; ex_data = data;
    ex_npc = 16'($urandom); ex_aluresult = 16'($urandom);
    ex_cs = 4'($urandom); ex_drid = 3'($urandom);
    cur_npc = ex_npc; cur_alu = ex_aluresult; cur_ir = ir; cur_cs = ex_cs; cur_drid = ex_drid;
    aw = {addr[15:1], 1'b0};
    w = mem[addr[15:1]];
    ptr = w;
    pw = {ptr[15:1], 1'b0};
    n_acc = 0; exp_data = data; exp_addr = addr; exp_memop = 1'b1;
    case (ir[15:12])
      4'b0010: begin
        n_acc = 1; acc[0] = mk(1, 0, addr, 16'h0, 2'b11);
        b = addr[0] ? w[15:8] : w[7:0];
        exp_data = 16'($signed(b));
      end
      4'b0110: begin n_acc = 1; acc[0] = mk(1, 0, aw, 16'h0, 2'b11); exp_data = w; end
      4'b1010: begin
        n_acc = 2; acc[0] = mk(1, 0, aw, 16'h0, 2'b11); acc[1] = mk(1, 0, pw, 16'h0, 2'b11);
        exp_data = mem[ptr[15:1]]; exp_addr = ptr;
      end
      4'b0011: begin
        n_acc = 1;
        acc[0] = mk(0, 1, addr, {data[7:0], data[7:0]}, addr[0] ? 2'b10 : 2'b01);
      end
      4'b0111: begin n_acc = 1; acc[0] = mk(0, 1, aw, data, 2'b11); end
      4'b1011: begin
        n_acc = 2; acc[0] = mk(1, 0, aw, 16'h0, 2'b11); acc[1] = mk(0, 1, pw, data, 2'b11);
        exp_addr = ptr;
      end
      default: exp_memop = 1'b0;
    endcase
    acc_idx = 0; done = 0; active = 1; obs_stall = 0;
  endtask

  // memory responder: random wait states, spurious resp when nothing is requested
  always @(posedge clk) begin
    #2;
    if (dmem_read || dmem_write) begin
      if (wait_cnt <= 0) begin
        dmem_resp  = 1'b1;
        dmem_rdata = mem[dmem_address[15:1]];
        wait_cnt   = $urandom_range(0, 3);
      end else begin
        dmem_resp  = 1'b0;
        dmem_rdata = 16'($urandom);
        wait_cnt--;
      end
    end else begin
      dmem_resp  = ($urandom_range(0, 5) == 0);
      dmem_rdata = 16'($urandom);
    end
  end

  // per-cycle compare against the access-list model
  always @(negedge clk) begin
    bit exp_load;
    if (!rst_n) begin
      chk("rst_read", dmem_read, 0);
      chk("rst_write", dmem_write, 0);
      chk("rst_wb_load", wb_load, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_perf_stall", perf_stall_cycles, 0);
      chk("rst_perf_ops", perf_mem_ops, 0);
    end else begin
`ifdef LC3B_MEM_STAGE_PERF_EN
      chk("perf_stall", perf_stall_cycles, exp_stall);
      chk("perf_ops", perf_mem_ops, exp_ops);
`else
      chk("perf_stall_off", perf_stall_cycles, 0);
      chk("perf_ops_off", perf_mem_ops, 0);
`endif
      if (!ex_valid) begin
        chk("idle_read", dmem_read, 0);
        chk("idle_write", dmem_write, 0);
        chk("idle_wb_load", wb_load, 0);
        chk("idle_stall", mem_stall, 0);
      end else if (active && !done) begin
        if (acc_idx < n_acc) begin
          chk("read", dmem_read, acc[acc_idx].rd);
          chk("write", dmem_write, acc[acc_idx].wr);
          chk("address", dmem_address, acc[acc_idx].addr);
          if (acc[acc_idx].wr) begin
            chk("wdata", dmem_wdata, acc[acc_idx].wdata);
            chk("byte_enable", dmem_byte_enable, acc[acc_idx].be);
          end
          if (acc_idx == 0) begin
            obs_a0 = dmem_address; obs_wd0 = dmem_wdata; obs_be0 = dmem_byte_enable; obs_wr0 = dmem_write;
          end
        end else begin
          chk("nonmem_read", dmem_read, 0);
          chk("nonmem_write", dmem_write, 0);
        end
        exp_load = (n_acc == 0) || (dmem_resp && acc_idx == n_acc - 1);
        chk("wb_load", wb_load, exp_load);
        chk("mem_stall", mem_stall, !exp_load);
        if (exp_load) begin
          chk("wb_data", wb_data, exp_data);
          chk("wb_address", wb_address, exp_addr);
          chk("wb_npc", wb_npc, cur_npc);
          chk("wb_aluresult", wb_aluresult, cur_alu);
          chk("wb_ir", wb_ir, cur_ir);
          chk("wb_cs", wb_cs, cur_cs);
          chk("wb_drid", wb_drid, cur_drid);
          obs_data = wb_data; obs_addr = wb_address;
          done = 1;
          if (exp_memop) exp_ops++;
        end else begin
          exp_stall++;
          obs_stall++;
        end
        if (dmem_resp && acc_idx < n_acc) begin
          if (acc[acc_idx].wr) begin
            if (acc[acc_idx].be[1]) mem[acc[acc_idx].addr[15:1]][15:8] = acc[acc_idx].wdata[15:8];
            if (acc[acc_idx].be[0]) mem[acc[acc_idx].addr[15:1]][7:0]  = acc[acc_idx].wdata[7:0];
          end
          acc_idx++;
        end
      end
    end
  end

  task automatic wait_done();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    chk("completion_timeout", done, 1);
  endtask

  task automatic run(input logic [15:0] ir, input logic [15:0] addr, input logic [15:0] data,
                     input int waits);
    @(posedge clk); #1;
    issue(ir, addr, data);
    if (waits >= 0) wait_cnt = waits;
    wait_done();
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    ex_valid = 1'b0; active = 0;
    ex_ir = 16'($urandom); ex_address = 16'($urandom); ex_data = 16'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; ex_valid = 1'b0; active = 0; exp_stall = 0; exp_ops = 0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] memops [6];
    logic [15:0] ir;
    memops = '{4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011};
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[16'h3000 >> 1] = 16'hBEEF;
    mem[16'h4000 >> 1] = 16'h80FF;
    mem[16'h5000 >> 1] = 16'h6000;
    mem[16'h7000 >> 1] = 16'h7100;
    mem[16'h7100 >> 1] = 16'hCAFE;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // ADD passes straight through
    run(16'h1042, 16'h0123, 16'h5A5A, -1);
    chk("add_wb_data", obs_data, 16'h5A5A);
    chk("add_stall_cycles", obs_stall, 0);

    run(16'h6000, 16'h3001, 16'h0000, 2);
    chk("ldw_addr", obs_a0, 16'h3000);
    chk("ldw_stall_cycles", obs_stall, 2);
    chk("ldw_data", obs_data, 16'hBEEF);

    run(16'h2000, 16'h4001, 16'h0000, 0);
    chk("ldb_data", obs_data, 16'hFF80);

    run(16'h3000, 16'h4000, 16'h12AB, 1);
    chk("stb_wdata", obs_wd0, 16'hABAB);
    chk("stb_be", obs_be0, 2'b01);
    chk("stb_write", obs_wr0, 1);

    do_reset();
    run(16'hB000, 16'h5000, 16'h1234, 1);
    chk("sti_wb_address", obs_addr, 16'h6000);
    chk("sti_mem", mem[16'h6000 >> 1], 16'h1234);
    idle_cycle();
    #1;
`ifdef LC3B_MEM_STAGE_PERF_EN
    chk("sti_perf_ops", perf_mem_ops, 1);
`endif

    // LDI interrupted by reset while its second access is pending
    @(posedge clk); #1;
    issue(16'hA000, 16'h7000, 16'h0000);
    wait_cnt = 0;
    @(posedge clk); #1;
    wait_cnt = 5;
    #2;
    chk("ldi_ind_read", dmem_read, 1);
    chk("ldi_ind_addr", dmem_address, 16'h7100);
    rst_n = 1'b0; ex_valid = 1'b0; active = 0; exp_stall = 0; exp_ops = 0;
    #1;
    chk("ldi_rst_read", dmem_read, 0);
    chk("ldi_rst_write", dmem_write, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    run(16'h6000, 16'h3000, 16'h0000, 1);
    chk("post_rst_ldw_data", obs_data, 16'hBEEF);
    chk("post_rst_ldw_addr", obs_a0, 16'h3000);

    // randomized mix, weighted toward memory opcodes
    for (int n = 0; n < 400; n++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 9) < 7) ir[15:12] = memops[$urandom_range(0, 5)];
      run(ir, 16'($urandom), 16'($urandom), -1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
      if (n == 200) do_reset();
    end
    idle_cycle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lc3b_mem_stage.md
# lc3b_mem_stage

Memory-access stage of the lc3b pipeline. Sits between the EX/MEM stage register and the MEM/WB stage register. Decodes the memory opcode from the in-flight instruction and sequences one or two data-memory transactions (two for LDI/STI). Produces the load strobe and field values that the MEM/WB register captures, and stalls upstream until the access completes.

## Interface
Parameters: none; all widths come from `lc3b_types` (`lc3b_word` = 16, `lc3b_four` = 4, `lc3b_nzp` = 3).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  EX/MEM holds a valid instruction. Held stable with all `ex_*` fields while `mem_stall`=1.
- `ex_address`, `ex_data`, `ex_npc`, `ex_aluresult`, `ex_ir`  in  16 each  EX/MEM fields: effective address, store data, NPC, ALU result, instruction.
- `ex_cs`  in  4  control bits, passed through untouched.
- `ex_drid`  in  3  destination register id, passed through.
- `dmem_address`  out  16  data-memory address.
- `dmem_wdata`  out  16  store data.
- `dmem_byte_enable`  out  2  write byte lanes.
- `dmem_read`, `dmem_write`  out  1  request strobes.
- `dmem_rdata`  in  16  read data.
- `dmem_resp`  in  1  one-cycle completion of the current request.
- `wb_load`  out  1  load enable for every MEM/WB register field.
- `wb_address`, `wb_data`, `wb_npc`, `wb_aluresult`, `wb_ir`  out  16  values for MEM/WB.
- `wb_cs`  out  4  value for MEM/WB.
- `wb_drid`  out  3  value for MEM/WB.
- `mem_stall`  out  1  freezes PC and all upstream stage registers.
- `perf_stall_cycles`, `perf_mem_ops`  out  32  performance counters; see Configuration.

## Operation
- Opcode decode uses `ex_ir[15:12]`:
  - LDB 0010, LDW 0110, LDI 1010: reads.
  - STB 0011, STW 0111, STI 1011: writes.
  - All other opcodes are non-memory.
- FSM states:
  - IDLE: first access, or pass-through.
  - IND: second access of LDI/STI.
- IDLE, `ex_valid`=1, non-memory opcode: `wb_load`=1 the same cycle, no strobe, `mem_stall`=0.
- IDLE, memory opcode: drive the access to `ex_address`.
  - LDI and STI: the first access is always a word read of the pointer.
  - On `dmem_resp` with LDI/STI: latch `dmem_rdata` into `ind_addr` and go to IND.
  - On `dmem_resp` otherwise: complete.
- IND: drive the second access to `ind_addr`.
  - LDI: word read. STI: word write.
  - On `dmem_resp`: complete and return to IDLE.
- Complete means `wb_load`=1 in the `dmem_resp` cycle.
- `mem_stall` = `ex_valid` & ~`wb_load`.
- Word accesses:
  - `dmem_address` = {addr[15:1],0}.
  - `dmem_byte_enable` = 11.
- Byte accesses:
  - `dmem_address` = addr.
  - STB: `dmem_wdata` = {data[7:0],data[7:0]}; `dmem_byte_enable` = 10 if addr[0]=1, else 01.
- Load results:
  - LDB `wb_data` = sign-extended selected byte; addr[0]=1 selects rdata[15:8].
  - LDW/LDI `wb_data` = `dmem_rdata`.
- All other instructions: `wb_data` = `ex_data`.
- `wb_address` = `ind_addr` for LDI/STI, otherwise `ex_address`.
- `wb_cs`, `wb_npc`, `wb_aluresult`, `wb_ir`, `wb_drid` = the matching `ex_*` input.
- `dmem_read`/`dmem_write` stay high until `dmem_resp`. The address and data do not change while a strobe is high.
- Back-to-back requests are legal: a new strobe may follow `dmem_resp` on the next cycle.
- `dmem_resp` while no strobe is high is ignored.

## Timing
- Reset values:
  - state = IDLE; `ind_addr` = 0; perf counters = 0.
  - `dmem_read`, `dmem_write`, `wb_load`, `mem_stall` are forced to 0 while `rst_n`=0, regardless of inputs.
- Latency:
  - Non-memory: 0 cycles.
  - Single access: N+1 cycles of `ex_valid`, where N = wait cycles before `dmem_resp`.
  - Indirect: (N1+1)+(N2+1) cycles.
- `dmem_resp` in the first cycle of a request is a valid 0-wait response.
- Reset mid-access: the access is abandoned and the state returns to IDLE. After `rst_n` rises, the first edge starts from IDLE.

## Configuration
- Macro `LC3B_MEM_STAGE_PERF_EN`.
- Defined:
  - `perf_stall_cycles` increments on every cycle with `mem_stall`=1.
  - `perf_mem_ops` increments on every completion of a memory opcode (LDI/STI count once).
  - Both counters saturate at 0xFFFFFFFF and clear only on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- ADD, `ex_valid`=1 → `wb_load`=1 same cycle; `mem_stall`=0; no strobe; `wb_data` = `ex_data`.
- LDW at 0x3001, `dmem_resp` after 2 waits, rdata 0xBEEF → `dmem_address` 0x3000, `mem_stall` high 2 cycles, `wb_data` 0xBEEF.
- LDB at 0x4001, rdata 0x80FF → `wb_data` 0xFF80.
- STB at 0x4000, data 0x12AB → `dmem_wdata` 0xABAB, `dmem_byte_enable` 01, `dmem_write`=1.
- STI at 0x5000:
  - First access: read returns 0x6000.
  - Second access: write of `ex_data` 0x1234 to 0x6000.
  - On completion: `wb_address` 0x6000; `perf_mem_ops`=1 when the macro is defined.
- LDI with `rst_n` pulsed low during the IND state → strobes drop at once; state = IDLE; the next LDW runs normally.
